fir_seq: RTL and testbench

- Sequencer that sits directly upstream of the bit-serial symmetric FIR core and also captures its result.
- Accepts coefficient words on a write strobe and serialises them MSB-first onto the core's coeff_load_in/coeff_in pins.
- Accepts samples over a valid/ready handshake, issues a one-cycle start with the sample held on x, and times the core's fixed compute window.
- Latches the core's y at the end of the window and presents it on a valid/ready output port.

---
 rtl/fir_seq.sv | 164 ++++++++++++++++
 tb/tb_fir_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq.sv
// fir_seq: sequencer in front of the bit-serial symmetric FIR core.
// Serialises coefficient words MSB-first onto the core's load pins. Feeds one
// sample per start pulse, times the core's fixed compute window, and then
// presents the captured result on a valid/ready output port.
//
// Handshake rules for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1. s_ready and m_valid depend only on
// registered state. The one exception is that s_ready is also cleared while
// coeff_wr is high, so a coefficient write wins a same-cycle collision. A
// producer that holds m_valid keeps m_data stable until the transfer.
module fir_seq #(
    parameter int BITS = 8,
    parameter int TAPS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            coeff_wr,
    input  logic [BITS-1:0] coeff_data,
    output logic            coeff_busy,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    output logic            fir_start,
    output logic [BITS-1:0] fir_x,
    output logic            fir_coeff_load,
    output logic            fir_coeff_bit,
    input  logic [BITS-1:0] fir_y,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BITS-1:0] m_data
);

    // Core compute cycles per sample.
    localparam int N  = BITS * (TAPS / 2);
    localparam int CW = $clog2(N + 1);
    localparam int BW = $clog2(BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic            fir_start_q, fir_start_d;
    logic [BITS-1:0] fir_x_q, fir_x_d;
    logic            fir_coeff_load_q, fir_coeff_load_d;
    logic            fir_coeff_bit_q, fir_coeff_bit_d;
    logic            m_valid_q, m_valid_d;
    logic [BITS-1:0] m_data_q, m_data_d;
    logic            s_ready_w;

    // Ready/busy flags come from state and result registers only. A coeff_wr
    // that arrives in the same cycle withdraws s_ready so the coefficient wins.
    always_comb begin
        s_ready_w  = (state_q == IDLE) && !m_valid_q && !coeff_wr;
        coeff_busy = (state_q != IDLE) || m_valid_q;
    end

    // Next-state logic and next values for every registered core/result output.
    always_comb begin
        state_d          = state_q;
        shreg_d          = shreg_q;
        bit_cnt_d        = bit_cnt_q;
        cyc_cnt_d        = cyc_cnt_q;
        fir_start_d      = 1'b0;
        fir_x_d          = fir_x_q;
        fir_coeff_load_d = 1'b0;
        fir_coeff_bit_d  = 1'b0;
        m_valid_d        = m_valid_q;
        m_data_d         = m_data_q;
        case (state_q)
            IDLE: begin
                if (coeff_wr && !m_valid_q) begin
                    // The MSB goes straight onto the core pins. The shift
                    // register keeps the remaining bits, aligned to its MSB.
                    fir_coeff_load_d = 1'b1;
                    fir_coeff_bit_d  = coeff_data[BITS-1];
                    shreg_d          = {coeff_data[BITS-2:0], 1'b0};
                    bit_cnt_d        = '0;
                    state_d          = LOAD;
                end else if (s_valid && s_ready_w) begin
                    fir_x_d     = s_data;
                    fir_start_d = 1'b1;
                    state_d     = START;
                end
            end
            LOAD: begin
                if (bit_cnt_q == BW'(BITS - 1)) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d        = bit_cnt_q + BW'(1);
                    fir_coeff_load_d = 1'b1;
                    fir_coeff_bit_d  = shreg_q[BITS-1];
                    shreg_d          = {shreg_q[BITS-2:0], 1'b0};
                end
            end
            START: begin
                cyc_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                // At cyc_cnt == N the core has had its full window, so y is final.
                if (cyc_cnt_q == CW'(N)) begin
                    m_data_d  = fir_y;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any operation and drops a pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            shreg_q          <= '0;
            bit_cnt_q        <= '0;
            cyc_cnt_q        <= '0;
            fir_start_q      <= 1'b0;
            fir_x_q          <= '0;
            fir_coeff_load_q <= 1'b0;
            fir_coeff_bit_q  <= 1'b0;
            m_valid_q        <= 1'b0;
            m_data_q         <= '0;
        end else begin
            state_q          <= state_d;
            shreg_q          <= shreg_d;
            bit_cnt_q        <= bit_cnt_d;
            cyc_cnt_q        <= cyc_cnt_d;
            fir_start_q      <= fir_start_d;
            fir_x_q          <= fir_x_d;
            fir_coeff_load_q <= fir_coeff_load_d;
            fir_coeff_bit_q  <= fir_coeff_bit_d;
            m_valid_q        <= m_valid_d;
            m_data_q         <= m_data_d;
        end
    end

    assign s_ready        = s_ready_w;
    assign fir_start      = fir_start_q;
    assign fir_x          = fir_x_q;
    assign fir_coeff_load = fir_coeff_load_q;
    assign fir_coeff_bit  = fir_coeff_bit_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: bench for fir_seq with a behavioural stand-in for the FIR core.
// The stand-in returns y = x*coeff + 8'h11, and it drives the inverted value
// until its N-cycle window has elapsed.
module tb_fir_seq;

    localparam int BITS = 8;
    localparam int TAPS = 4;
    localparam int N    = BITS * (TAPS / 2);

    logic            clk;
    logic            rst_n;
    logic            coeff_wr;
    logic [BITS-1:0] coeff_data;
    logic            coeff_busy;
    logic            s_valid;
    logic            s_ready;
    logic [BITS-1:0] s_data;
    logic            fir_start;
    logic [BITS-1:0] fir_x;
    logic            fir_coeff_load;
    logic            fir_coeff_bit;
    logic [BITS-1:0] fir_y;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;

    fir_seq #(.BITS(BITS), .TAPS(TAPS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coeff_wr       (coeff_wr),
        .coeff_data     (coeff_data),
        .coeff_busy     (coeff_busy),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .fir_start      (fir_start),
        .fir_x          (fir_x),
        .fir_coeff_load (fir_coeff_load),
        .fir_coeff_bit  (fir_coeff_bit),
        .fir_y          (fir_y),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- core stand-in ----------------
    logic [BITS-1:0] core_c, core_x, core_y;
    int              core_cnt;
    logic            core_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            core_c    <= '0;
            core_x    <= '0;
            core_y    <= '0;
            core_cnt  <= 0;
            core_busy <= 1'b0;
        end else begin
            if (fir_coeff_load) core_c <= {core_c[BITS-2:0], fir_coeff_bit};
            if (fir_start) begin
                core_x    <= fir_x;
                core_busy <= 1'b1;
                core_cnt  <= 1;
                core_y    <= ~y_ref(fir_x, core_c);
            end else if (core_busy) begin
                if (core_cnt == N) begin
                    core_y    <= y_ref(core_x, core_c);
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end
    assign fir_y = core_y;

    function automatic logic [BITS-1:0] y_ref(input logic [BITS-1:0] x, input logic [BITS-1:0] c);
        logic [2*BITS-1:0] p;
        p = x * c;
        return p[BITS-1:0] + 8'h11;
    endfunction

    // ---------------- scoreboard ----------------
    int              total = 0;
    int              bad   = 0;
    logic [BITS-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int   hs_cyc     = -1;
    int   hs_cnt     = 0;
    int   st_cnt     = 0;
    int   excl_viol  = 0;
    logic mv_prev    = 1'b0;

    // Negedge monitor: the values seen here are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) begin
                hs_cyc = cyc + 1;
                hs_cnt++;
            end
            if (m_valid && !mv_prev && hs_cyc >= 0)
                check("latency", 32'(cyc - hs_cyc), 32'(N + 2));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: m_data %0h with no expected result", m_data);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            if (fir_start) st_cnt++;
            if (fir_start && fir_coeff_load) excl_viol++;
        end
        mv_prev = m_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_s_ready(input string name);
        int k = 0;
        while (!s_ready && k < 60) begin
            tick();
            k++;
        end
        if (!s_ready) check(name, 32'(s_ready), 32'd1);
    endtask

    task automatic load_coeff(input logic [BITS-1:0] c);
        logic [BITS-1:0] seq;
        int              len;
        logic            busy_ok;
        logic            start_seen;
        int              k = 0;
        while (coeff_busy && k < 60) begin
            tick();
            k++;
        end
        coeff_wr   = 1'b1;
        coeff_data = c;
        tick();
        coeff_wr   = 1'b0;
        coeff_data = BITS'($urandom_range(0, 255));
        seq        = '0;
        len        = 0;
        busy_ok    = 1'b1;
        start_seen = 1'b0;
        while (fir_coeff_load && len < 20) begin
            seq        = {seq[BITS-2:0], fir_coeff_bit};
            len++;
            busy_ok    = busy_ok & coeff_busy;
            start_seen = start_seen | fir_start;
            tick();
        end
        check("load_len", 32'(len), 32'(BITS));
        check("load_bits", 32'(seq), 32'(c));
        check("load_busy", 32'(busy_ok), 32'd1);
        check("load_no_start", 32'(start_seen), 32'd0);
        check("load_done_busy", 32'(coeff_busy), 32'd0);
    endtask

    // Caller has s_valid=1, s_data=x and s_ready=1, so the next edge is the handshake.
    task automatic hs_and_finish(input logic [BITS-1:0] x, input logic [BITS-1:0] exp, input int hold);
        logic [BITS-1:0] held;
        int              bp_err;
        int              k;
        exp_q.push_back(exp);
        tick();
        s_valid = 1'b0;
        s_data  = BITS'($urandom_range(0, 255));
        check("start_high", 32'(fir_start), 32'd1);
        check("fir_x", 32'(fir_x), 32'(x));
        tick();
        check("start_pulse", 32'(fir_start), 32'd0);
        k = 0;
        while (!m_valid && k < 40) begin
            tick();
            k++;
        end
        if (!m_valid) check("m_valid_timeout", 32'(m_valid), 32'd1);
        if (!m_ready) begin
            held   = m_data;
            bp_err = 0;
            for (int i = 0; i < hold; i++) begin
                coeff_wr   = (i != hold - 1);
                coeff_data = 8'h5A;
                tick();
                if (m_data !== held || s_ready !== 1'b0 || m_valid !== 1'b1 ||
                    fir_coeff_load !== 1'b0 || coeff_busy !== 1'b1)
                    bp_err++;
            end
            coeff_wr = 1'b0;
            if (hold > 0) check("backpressure", 32'(bp_err), 32'd0);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check("drain_m_valid", 32'(m_valid), 32'd0);
            check("drain_s_ready", 32'(s_ready), 32'd1);
        end
    endtask

    task automatic run_sample(input logic [BITS-1:0] x, input logic [BITS-1:0] exp, input int hold);
        wait_s_ready("s_ready_timeout");
        s_valid = 1'b1;
        s_data  = x;
        hs_and_finish(x, exp, hold);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [BITS-1:0] coeff;
        logic            reload;
        logic [BITS-1:0] x;
        int              hold;
        logic [BITS-1:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int k;
        int mv_seen;

        // y = x*c + 8'h11, truncated to 8 bits
        tbl[0] = '{coeff: 8'h01, reload: 1'b1, x: 8'h03, hold: 0,  exp: 8'h14};
        tbl[1] = '{coeff: 8'hA5, reload: 1'b1, x: 8'h3C, hold: 10, exp: 8'hBD};
        tbl[2] = '{coeff: 8'hA5, reload: 1'b0, x: 8'h02, hold: 0,  exp: 8'h5B};
        tbl[3] = '{coeff: 8'hFF, reload: 1'b1, x: 8'hFF, hold: 2,  exp: 8'h12};
        tbl[4] = '{coeff: 8'h80, reload: 1'b1, x: 8'h01, hold: 0,  exp: 8'h91};
        tbl[5] = '{coeff: 8'h00, reload: 1'b1, x: 8'h7E, hold: 1,  exp: 8'h11};
        tbl[6] = '{coeff: 8'h13, reload: 1'b1, x: 8'hEE, hold: 3,  exp: 8'hBB};

        // Reset with both request inputs active.
        rst_n      = 1'b0;
        coeff_wr   = 1'b1;
        coeff_data = 8'hC3;
        s_valid    = 1'b1;
        s_data     = 8'h77;
        m_ready    = 1'b0;
        repeat (3) tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_outputs",
              32'({fir_start, fir_coeff_load, fir_coeff_bit, m_valid, fir_x, m_data}), 32'd0);
        rst_n    = 1'b1;
        coeff_wr = 1'b0;
        s_valid  = 1'b0;
        tick();
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_busy", 32'(coeff_busy), 32'd0);

        // Coefficient serialisation of A5.
        load_coeff(8'hA5);

        // Table-driven samples.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].reload) load_coeff(tbl[i].coeff);
            run_sample(tbl[i].x, tbl[i].exp, tbl[i].hold);
        end

        // Collision: the coefficient write wins, and the held sample goes in after LOAD.
        wait_s_ready("collide_wait");
        coeff_wr   = 1'b1;
        coeff_data = 8'h07;
        s_valid    = 1'b1;
        s_data     = 8'h09;
        #1;
        check("collide_s_ready", 32'(s_ready), 32'd0);
        tick();
        coeff_wr = 1'b0;
        check("collide_load", 32'(fir_coeff_load), 32'd1);
        check("collide_no_start", 32'(fir_start), 32'd0);
        k = 0;
        while (!s_ready && k < 30) begin
            tick();
            k++;
        end
        check("collide_wait_cycles", 32'(k), 32'(BITS));
        hs_and_finish(8'h09, y_ref(8'h09, 8'h07), 2);

        // Continuous m_ready and s_valid: three samples in a row.
        m_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            logic [BITS-1:0] xv;
            xv = BITS'($urandom_range(0, 255));
            wait_s_ready("stream_wait");
            s_valid = 1'b1;
            s_data  = xv;
            exp_q.push_back(y_ref(xv, 8'h07));
            tick();
            s_valid = 1'b0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b0;

        // Reset in the middle of RUN (cyc_cnt = 7) discards the sample.
        wait_s_ready("rst_run_wait");
        s_valid = 1'b1;
        s_data  = 8'h44;
        tick();
        s_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n   = 1'b1;
        mv_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (m_valid) mv_seen++;
        end
        check("rst_run_no_result", 32'(mv_seen), 32'd0);
        load_coeff(8'h05);
        run_sample(8'h04, 8'h25, 1);

        // Final consistency checks.
        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("start_load_exclusive", 32'(excl_viol), 32'd0);
        check("one_start_per_sample", 32'(st_cnt), 32'(hs_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
